// File: rtl/axis_mt19937_if.sv
// axis_mt19937_if: AXI4-Stream word channel between an MT19937 source and its checker
interface axis_mt19937_if;
  logic [31:0] tdata;
  logic tvalid;
  logic tready;
  modport master(output tdata, output tvalid, input tready);
  modport slave(input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_mt19937_checker.sv
// axis_mt19937_checker: clones MT19937 state from 624 observed words, then checks every later word
module axis_mt19937_checker #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  axis_mt19937_if.slave          input_axis,
  input  logic                   relearn,
  output logic                   locked,
  output logic                   match,
  output logic                   mismatch,
  output logic [31:0]            expected,
  output logic [COUNT_WIDTH-1:0] match_count,
  output logic [COUNT_WIDTH-1:0] error_count,
  output logic                   busy
);
  localparam logic [1:0] LEARN = 2'd0;
  localparam logic [1:0] PRIME = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;
  localparam logic [9:0] LAST = 10'd623;
  localparam logic [9:0] SHIFT = 10'd397;
  localparam logic [31:0] MATRIX_A = 32'h9908B0DF;

  function automatic logic [31:0] temper(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x >> 11);
    y = y ^ ((y << 7) & 32'h9D2C5680);
    y = y ^ ((y << 15) & 32'hEFC60000);
    return y ^ (y >> 18);
  endfunction

  function automatic logic [31:0] untemper(input logic [31:0] x);
    logic [31:0] y, t;
    y = x ^ (x >> 18);
    y = y ^ ((y << 15) & 32'hEFC60000);
    t = y;
    for (int i = 0; i < 4; i++) t = y ^ ((t << 7) & 32'h9D2C5680);
    y = t;
    for (int i = 0; i < 2; i++) t = y ^ (t >> 11);
    return t;
  endfunction

  function automatic logic [9:0] wrap_inc(input logic [9:0] p);
    return p == LAST ? 10'd0 : p + 10'd1;
  endfunction

  logic [31:0] mem_q [0:623];
  logic [31:0] rd_a_q, rd_b_q;
  logic [1:0] state_q, state_d;
  logic [9:0] idx_q, idx_d, ptr_a_q, ptr_a_d, ptr_b_q, ptr_b_d;
  logic prime_q, prime_d, tready_q, tready_d;
  logic match_q, match_d, mismatch_q, mismatch_d;
  logic [31:0] save_q, save_d, expected_q, expected_d;
  logic [COUNT_WIDTH-1:0] match_count_q, match_count_d, error_count_q, error_count_d;
  logic learning, priming, checking, acc, step, hit;
  logic we, re_a, re_b;
  logic [9:0] ra, rb;
  logic [31:0] y, n, pred, wd;

  always_comb begin
    learning = state_q == LEARN;
    priming = state_q == PRIME;
    checking = state_q == CHECK;
    acc = input_axis.tvalid && tready_q && !relearn;
    step = checking && acc;
    y = {save_q[31], rd_a_q[30:0]};
    n = rd_b_q ^ (y >> 1) ^ (y[0] ? MATRIX_A : 32'd0);
    pred = temper(n);
    hit = input_axis.tdata == pred;
    we = acc;
    wd = checking ? n : untemper(input_axis.tdata);
    re_a = priming || step;
    re_b = (priming && !prime_q) || step;
    ra = priming ? {9'd0, prime_q} : wrap_inc(ptr_a_q);
    rb = priming ? SHIFT : wrap_inc(ptr_b_q);
    state_d = relearn ? LEARN :
              (learning && acc && idx_q == LAST) ? PRIME :
              (priming && prime_q) ? CHECK : state_q;
    idx_d = relearn ? 10'd0 : acc ? wrap_inc(idx_q) : idx_q;
    prime_d = priming && !prime_q;
    ptr_a_d = priming ? 10'd1 : step ? wrap_inc(ptr_a_q) : ptr_a_q;
    ptr_b_d = priming ? SHIFT : step ? wrap_inc(ptr_b_q) : ptr_b_q;
    save_d = ((priming && prime_q) || step) ? rd_a_q : save_q;
    tready_d = state_d != PRIME;
    match_d = step && hit;
    mismatch_d = step && !hit;
    expected_d = step ? pred : expected_q;
    match_count_d = relearn ? '0 : match_d ? match_count_q + COUNT_WIDTH'(~&match_count_q) : match_count_q;
    error_count_d = relearn ? '0 : mismatch_d ? error_count_q + COUNT_WIDTH'(~&error_count_q) : error_count_q;
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[idx_q] <= wd;
    if (re_a) rd_a_q <= mem_q[ra];
    if (re_b) rd_b_q <= mem_q[rb];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LEARN;
      idx_q <= '0;
      ptr_a_q <= '0;
      ptr_b_q <= '0;
      prime_q <= 1'b0;
      save_q <= '0;
      tready_q <= 1'b0;
      match_q <= 1'b0;
      mismatch_q <= 1'b0;
      expected_q <= '0;
      match_count_q <= '0;
      error_count_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      ptr_a_q <= ptr_a_d;
      ptr_b_q <= ptr_b_d;
      prime_q <= prime_d;
      save_q <= save_d;
      tready_q <= tready_d;
      match_q <= match_d;
      mismatch_q <= mismatch_d;
      expected_q <= expected_d;
      match_count_q <= match_count_d;
      error_count_q <= error_count_d;
    end
  end

  assign input_axis.tready = tready_q;
  assign locked = state_q == CHECK;
  assign busy = state_q == PRIME;
  assign match = match_q;
  assign mismatch = mismatch_q;
  assign expected = expected_q;
  assign match_count = match_count_q;
  assign error_count = error_count_q;
endmodule

// File: tb/tb_axis_mt19937_checker.sv
// tb_axis_mt19937_checker: scoreboard bench driving MT19937 streams into the checker
module tb_axis_mt19937_checker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic relearn = 1'b0;
  axis_mt19937_if ax();
  axis_mt19937_if ax4();
  assign ax4.tdata = ax.tdata;
  assign ax4.tvalid = ax.tvalid;

  logic locked, match, mismatch, busy;
  logic [31:0] expected, match_count, error_count;
  logic locked4, match4, mismatch4, busy4;
  logic [31:0] expected4;
  logic [3:0] mc4, ec4;

  axis_mt19937_checker dut (
    .clk(clk), .rst(rst), .input_axis(ax), .relearn(relearn),
    .locked(locked), .match(match), .mismatch(mismatch), .expected(expected),
    .match_count(match_count), .error_count(error_count), .busy(busy)
  );

  axis_mt19937_checker #(.COUNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .input_axis(ax4), .relearn(relearn),
    .locked(locked4), .match(match4), .mismatch(mismatch4), .expected(expected4),
    .match_count(mc4), .error_count(ec4), .busy(busy4)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] q_exp[$];
  bit q_good[$];
  logic [31:0] g_mt [0:623];
  int g_i;
  int fed;
  logic [31:0] last_pred;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] temper(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x >> 11);
    y = y ^ ((y << 7) & 32'h9D2C5680);
    y = y ^ ((y << 15) & 32'hEFC60000);
    return y ^ (y >> 18);
  endfunction

  task automatic start(input logic [31:0] seed);
    g_mt[0] = seed;
    for (int i = 1; i < 624; i++) g_mt[i] = 32'd1812433253 * (g_mt[i-1] ^ (g_mt[i-1] >> 30)) + 32'(i);
    g_i = 624;
    fed = 0;
  endtask

  task automatic gen(output logic [31:0] w);
    if (g_i >= 624) begin
      for (int i = 0; i < 624; i++) begin
        logic [31:0] y;
        y = (g_mt[i] & 32'h80000000) | (g_mt[(i + 1) % 624] & 32'h7FFFFFFF);
        g_mt[i] = g_mt[(i + 397) % 624] ^ (y >> 1) ^ (y[0] ? 32'h9908B0DF : 32'd0);
      end
      g_i = 0;
    end
    w = temper(g_mt[g_i]);
    g_i++;
  endtask

  task automatic send(input logic [31:0] w, input bit c, input logic [31:0] pred, output int waits);
    waits = 0;
    ax.tdata = w;
    ax.tvalid = 1'b1;
    while (!ax.tready && waits < 20) begin
      chk("busy_while_stalled", busy, 1);
      @(negedge clk);
      waits++;
    end
    if (!ax.tready) chk("accept_timeout", 0, 1);
    else if (c) begin
      q_exp.push_back(pred);
      q_good.push_back(w == pred);
    end
    @(negedge clk);
    ax.tvalid = 1'b0;
  endtask

  task automatic feed(input int n, input int err_at, input bit gap);
    for (int k = 0; k < n; k++) begin
      logic [31:0] w, obs;
      int waits;
      bit c;
      gen(w);
      c = fed >= 624;
      obs = (c && fed - 624 == err_at) ? w ^ 32'h1 : w;
      if (gap) while ($urandom_range(0, 1) == 1) begin
        ax.tvalid = 1'b0;
        @(negedge clk);
      end
      send(obs, c, w, waits);
      if (fed == 624 && !gap) begin
        chk("prime_stall_cycles", waits, 2);
        chk("locked_after_prime", locked, 1);
      end
      if (c) last_pred = w;
      fed++;
    end
  endtask

  task automatic drain();
    ax.tvalid = 1'b0;
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", q_exp.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ax.tvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_tready", ax.tready, 0);
    chk("rst_locked", locked, 0);
    chk("rst_pulses", {match, mismatch}, 0);
    chk("rst_expected", expected, 0);
    chk("rst_match_count", match_count, 0);
    chk("rst_error_count", error_count, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    chk("tready_after_rst", ax.tready, 1);
  endtask

  always @(negedge clk) begin
    if (!rst && (match || mismatch)) begin
      if (q_exp.size() == 0) chk("unexpected_pulse", {match, mismatch}, 0);
      else begin
        logic [31:0] e;
        bit g;
        e = q_exp.pop_front();
        g = q_good.pop_front();
        chk("pulse_kind", {match, mismatch}, {g, !g});
        chk("expected_word", expected, e);
      end
    end
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: run exceeded cycle budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] xv [0:3];
    logic [31:0] w;
    int waits;
    ax.tvalid = 1'b0;
    ax.tdata = '0;
    xv[0] = 32'h00000000;
    xv[1] = 32'hFFFFFFFF;
    xv[2] = 32'h80000000;
    xv[3] = 32'h00001571;
    do_reset();
    for (int i = 0; i < 4; i++) send(temper(xv[i]), 1'b0, 32'd0, waits);
    for (int i = 0; i < 4; i++) chk("untemper_mem", dut.mem_q[i], xv[i]);

    do_reset();
    start(32'd5489);
    gen(w);
    chk("model_first_word", w, 32'd3499211612);
    start(32'd5489);
    feed(1624, -1, 1'b0);
    drain();
    chk("t2_match_count", match_count, 1000);
    chk("t2_error_count", error_count, 0);

    do_reset();
    start(32'd5489);
    feed(1624, 10, 1'b0);
    drain();
    chk("t3_match_count", match_count, 999);
    chk("t3_error_count", error_count, 1);
    chk("t3_still_locked", locked, 1);

    do_reset();
    start(32'd5489);
    feed(2624, -1, 1'b1);
    drain();
    chk("t4_match_count", match_count, 2000);
    chk("t4_error_count", error_count, 0);

    do_reset();
    start(32'd5489);
    feed(1124, -1, 1'b0);
    drain();
    ax.tdata = 32'hDEADBEEF;
    ax.tvalid = 1'b1;
    relearn = 1'b1;
    @(negedge clk);
    relearn = 1'b0;
    ax.tvalid = 1'b0;
    chk("relearn_locked", locked, 0);
    chk("relearn_tready", ax.tready, 1);
    chk("relearn_match_count", match_count, 0);
    chk("relearn_error_count", error_count, 0);
    start(32'd1234);
    feed(724, -1, 1'b0);
    drain();
    chk("t5_match_count", match_count, 100);
    chk("t5_error_count", error_count, 0);

    do_reset();
    start(32'd5489);
    feed(924, -1, 1'b0);
    drain();
    do_reset();
    start(32'd5489);
    feed(634, -1, 1'b0);
    drain();
    chk("t6_match_count", match_count, 10);
    feed(10, -1, 1'b0);
    drain();
    chk("t6_match_count_20", match_count, 20);
    chk("t6_error_count", error_count, 0);
    chk("sat_match_count", mc4, 15);
    chk("sat_error_count", ec4, 0);
    chk("w4_locked", locked4, 1);
    chk("w4_busy", busy4, 0);
    chk("w4_pulses_idle", {match4, mismatch4}, 0);
    chk("w4_expected", expected4, last_pred);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/axis_mt19937_checker.md
Name: axis_mt19937_checker

Overview:
- AXI4-Stream sink that clones the state of an MT19937 generator from its output stream, then checks every later word against its own prediction.
- Placed downstream of the stream RNG, or at the far end of a link carrying it. Gives a self-contained pass/fail monitor for RNG datapaths, FIFOs and DMA paths on the Zynq fabric.
- Learns 624 consecutive words by inverting the tempering, then predicts each following word with an in-place incremental twist.

Parameters:
COUNT_WIDTH, 32, width of match_count and error_count; both saturate at all-ones.

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
input_axis_tdata  input  32  observed RNG word
input_axis_tvalid  input  1  word valid
input_axis_tready  output  1  sink ready
relearn  input  1  single-cycle pulse: discard state, restart learning from the next accepted word
locked  output  1  624 words learned; checking active
match  output  1  one-cycle pulse: checked word equal to prediction
mismatch  output  1  one-cycle pulse: checked word differs from prediction
expected  output  32  predicted word, registered with match/mismatch
match_count  output  COUNT_WIDTH  checked words that matched
error_count  output  COUNT_WIDTH  checked words that mismatched
busy  output  1  high in PRIME (input stalled)

Behaviour:
- Reset values:
  - state=LEARN, learn index=0.
  - input_axis_tready=0 during the reset cycle; registered to 1 on the first cycle after reset.
  - locked=0, match=0, mismatch=0, expected=0, counts=0, busy=0.
- Beat accepted when tvalid && tready.
- State memory: 624 x 32 array, one write port and two registered read ports.
- Untemper (combinational, exact inverse of MT19937 tempering), applied in this order:
  1. y ^= y>>18
  2. y ^= (y<<15)&0xEFC60000
  3. invert y ^= (y<<7)&0x9D2C5680, by 4 iterations of t = y_in ^ ((t<<7)&mask)
  4. invert y ^= y>>11, by 2 iterations
- States:
  - LEARN:
    - tready=1.
    - Each accepted beat writes untemper(tdata) to mt[idx] and increments idx.
    - On the accept with idx==623, go to PRIME; mti=0.
  - PRIME:
    - tready=0, busy=1, fixed 2 cycles.
    - Issues reads so that save=mt[0], rd_a=mt[1], rd_b=mt[397] are valid on exit.
    - Then go to CHECK; locked=1 from the first CHECK cycle.
  - CHECK:
    - tready=1; one beat per cycle sustained, no bubbles.
    - Per accepted beat at index mti:
      - y = {save[31], rd_a[30:0]}
      - n = rd_b ^ (y>>1) ^ (y[0] ? 0x9908B0DF : 0)
      - write mt[mti]=n
      - prediction = temper(n)
      - save ← rd_a
      - mti, ptr_a, ptr_b each increment modulo 624 (wrap 623→0)
    - Compare tdata to the prediction.
    - Next cycle: expected=prediction; exactly one of match/mismatch pulses; the matching count increments, saturating.
    - Without an accepted beat, match=mismatch=0 and state holds.
- Mismatch does not unlock. Prediction continues from the predicted value, never from the observed word.
- relearn in any state:
  - Next cycle: LEARN, idx=0, locked=0, counts=0, tready=1.
  - A beat presented in the relearn cycle is dropped: not learned, not counted.
- rst mid-operation: immediate return to reset values. Memory contents are irrelevant and need no clearing.
- Wrap: the read of mt[(i+397)%624] for i≥227 returns the already-updated word. A write at mti must be visible to a read issued ≥227 cycles later; no read-during-write hazard exists.
- Counts saturate; they never wrap.

Test Plan:
1. Untemper unit check: words temper(x) for x ∈ {0x00000000, 0xFFFFFFFF, 0x80000000, 0x00001571} learned at idx 0..3 → mt[0..3] read back equal to x exactly.
2. Lock and match: 624+1000 words from the generator seeded 5489 (first word 3499211612), tvalid always high.
   - locked rises 2 cycles after the 624th accept; tready low exactly those 2 cycles.
   - match_count=1000, error_count=0; expected equals each input word.
3. Error injection: as test 2, but XOR checked word #10 with 0x00000001.
   - Single mismatch pulse, error_count=1, match_count=999.
   - Predictions after the flipped word still match.
4. Backpressure and gaps: random tvalid (50% duty) over 624+2000 words → match_count=2000, error_count=0. Wrap past 623 is exercised 3+ times.
5. Relearn: pulse relearn at checked word 500, then stream from seed 1234 for 624+100 words → locked drops next cycle; after relock, match_count=100, error_count=0.
6. Reset mid-CHECK: assert rst for 1 cycle.
   - All outputs at reset values on the next cycle.
   - A fresh 624+10-word stream locks with match_count=10.
   - COUNT_WIDTH=4 with 20 matching words → match_count saturates at 15.
